// File: rtl/md_seq_ctrl_pkg.sv
// rtl/md_seq_ctrl_pkg.sv - shared op encodings, latencies and state type for the MD sequencer
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // mult/multu/div/divu occupy the unit; mthi/mtlo and nops do not
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_seq_ctrl_if.sv
// rtl/md_seq_ctrl_if.sv - E/D-stage request and HI/LO result bundle for the MD sequencer
interface md_seq_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output start, md_op, rs_val, rt_val, rd_hi, d_is_md,
        input  busy, stall, hi, lo, md_rdata
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, rd_hi, d_is_md,
        output busy, stall, hi, lo, md_rdata
    );
endinterface

// File: rtl/md_seq_ctrl_compute.sv
// rtl/md_seq_ctrl_compute.sv - combinational 32x32 multiply and divide datapath
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div_zero
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_b_zero;
    logic [31:0] w_udsr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor is replaced by 1 so the divider never sees x/0; the result is discarded anyway
    assign w_b_zero = (i_b == 32'd0);
    assign w_udsr   = w_b_zero ? 32'd1 : i_b;
    assign w_uq     = i_a / w_udsr;
    assign w_ur     = i_a % w_udsr;

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
    assign w_abs_a  = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_abs_b  = w_b_zero ? 32'd1 : (i_b[31] ? (~i_b + 32'd1) : i_b);
    assign w_sq_mag = w_abs_a / w_abs_b;
    assign w_sr_mag = w_abs_a % w_abs_b;
    assign w_sq     = (i_a[31] ^ i_b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr     = i_a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

    // Select the result pair for the requested operation
    always_comb begin
        o_hi_res   = 32'd0;
        o_lo_res   = 32'd0;
        o_div_zero = 1'b0;
        case (i_op)
            MD_MULT:  begin o_hi_res = w_smul[63:32]; o_lo_res = w_smul[31:0]; end
            MD_MULTU: begin o_hi_res = w_umul[63:32]; o_lo_res = w_umul[31:0]; end
            MD_DIV:   begin o_hi_res = w_sr; o_lo_res = w_sq; o_div_zero = w_b_zero; end
            MD_DIVU:  begin o_hi_res = w_ur; o_lo_res = w_uq; o_div_zero = w_b_zero; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_seq_ctrl.sv
// rtl/md_seq_ctrl.sv - HI/LO owner and fixed-latency busy sequencer for multiply/divide
module md_seq_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    md_seq_ctrl_if.slave  bus
);

    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    md_state_e   r_state;
    md_state_e   w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_stage_hi;
    logic [31:0] r_stage_lo;
    logic        r_stage_dz;

    logic        w_accept;
    logic        w_commit;
    logic        w_idle_start;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;
    logic        w_div_zero;

    md_compute u_compute (
        .i_op       (bus.md_op),
        .i_a        (bus.rs_val),
        .i_b        (bus.rt_val),
        .o_hi_res   (w_hi_res),
        .o_lo_res   (w_lo_res),
        .o_div_zero (w_div_zero)
    );

    assign w_idle_start = bus.start && (r_state == IDLE);
    assign w_accept     = w_idle_start && md_is_arith(bus.md_op);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next state and commit strobe
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next_state = BUSY;
            BUSY: if (r_cnt == 4'd1) begin
                w_next_state = IDLE;
                w_commit     = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Latency counter and result staging, loaded when an operation is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= 4'd0;
            r_stage_hi <= 32'd0;
            r_stage_lo <= 32'd0;
            r_stage_dz <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= (bus.md_op[1]) ? LP_DIV_N : LP_MULT_N;
            r_stage_hi <= w_hi_res;
            r_stage_lo <= w_lo_res;
            r_stage_dz <= w_div_zero;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // HI/LO architectural registers: commit from staging or direct mthi/mtlo
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_stage_dz) begin
                r_hi <= r_stage_hi;
                r_lo <= r_stage_lo;
            end
        end else if (w_idle_start && bus.md_op == MD_MTHI) begin
            r_hi <= bus.rs_val;
        end else if (w_idle_start && bus.md_op == MD_MTLO) begin
            r_lo <= bus.rs_val;
        end
    end

    assign bus.busy     = (r_state == BUSY);
    assign bus.stall    = bus.d_is_md && ((r_state == BUSY) || (bus.start && md_is_arith(bus.md_op)));
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.md_rdata = bus.rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb/tb_md_seq_ctrl.sv - directed self-checking bench for md_seq_ctrl
module tb_md_seq_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    md_seq_ctrl_if bus ();

    md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, then verify busy/stall for n cycles and release afterwards
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n, input logic dmd);
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.rs_val  = rs;
        bus.rt_val  = rt;
        bus.d_is_md = dmd;
        #1;
        chk({tag, "_stall_start"}, {31'd0, bus.stall}, {31'd0, dmd});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rs_val = 32'hDEAD_BEEF;
        bus.rt_val = 32'h0BAD_F00D;
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (dmd) chk({tag, "_stall_busy"}, {31'd0, bus.stall}, 32'd1);
            @(negedge clk);
        end
        chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
        bus.d_is_md = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.md_op   = 3'd7;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        bus.rd_hi   = 1'b0;
        bus.d_is_md = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'h0000_0000);

        // mthi writes at the sampling edge without going busy
        bus.start = 1'b1; bus.md_op = 3'd4; bus.rs_val = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi_hi", bus.hi, 32'h0000_1234);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);

        run_op("divu0", 3'd3, 32'd77, 32'd0, 10, 1'b0);
        chk("divu0_hi", bus.hi, 32'h0000_1234);
        chk("divu0_lo", bus.lo, 32'h8000_0000);

        bus.start = 1'b1; bus.md_op = 3'd5; bus.rs_val = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_lo", bus.lo, 32'd5);
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);

        // nop opcode changes nothing
        bus.start = 1'b1; bus.md_op = 3'd6; bus.rs_val = 32'h1111_1111;
        @(negedge clk);
        bus.start = 1'b0;
        chk("nop_hi", bus.hi, 32'h0000_1234);
        chk("nop_busy", {31'd0, bus.busy}, 32'd0);

        // Reset during busy cycle 4 aborts with no later commit
        bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy4", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_late_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_late_hi", bus.hi, 32'd0);
        chk("abort_late_lo", bus.lo, 32'd0);

        // Start forced while busy is ignored
        bus.start = 1'b1; bus.md_op = 3'd0; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovl_busy", {31'd0, bus.busy}, 32'd0);
        chk("ovl_hi", bus.hi, 32'd0);
        chk("ovl_lo", bus.lo, 32'd42);
        repeat (12) @(negedge clk);
        chk("ovl_late_busy", {31'd0, bus.busy}, 32'd0);
        chk("ovl_late_lo", bus.lo, 32'd42);

        // md_rdata follows rd_hi combinationally
        bus.start = 1'b1; bus.md_op = 3'd4; bus.rs_val = 32'hAAAA_5555;
        @(negedge clk);
        bus.md_op = 3'd5; bus.rs_val = 32'h5555_AAAA;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rd_hi = 1'b1;
        #1;
        chk("rdata_hi", bus.md_rdata, 32'hAAAA_5555);
        bus.rd_hi = 1'b0;
        #1;
        chk("rdata_lo", bus.md_rdata, 32'h5555_AAAA);
        bus.rd_hi = 1'b1;
        #1;
        chk("rdata_hi2", bus.md_rdata, 32'hAAAA_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
